z3_to_z1: RTL and testbench
===========================

Z3_TO_Z1 -- requirements
Module: z3_to_z1

Interface
REQ-001 The block SHALL have parameter IW, default 16, meaning the width of each signed polyphase lane input.
REQ-002 The block SHALL have parameter OW, default 11, meaning the width of the signed serial output (OW < IW).
REQ-003 The block SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_vld  input  1  one-cycle strobe: lanes valid.
REQ-006 The block SHALL have port in  input  3 x IW signed  polyphase lanes; in[0] newest, in[2] oldest.
REQ-007 The block SHALL have port out  output  OW signed  serial sample, registered.
REQ-008 The block SHALL have port out_vld  output  1  high when out carries a new sample.
REQ-009 The block SHALL have port busy  output  1  high while the serializer holds unsent samples.
REQ-010 The block SHALL have port ovf  output  1  sticky drop flag.

Function
REQ-011 The block SHALL use state IDLE or SHIFT plus phase counter ph in 0..2; ph advances 0->1->2 in SHIFT.
REQ-012 On in_vld in cycle n in IDLE, the block SHALL capture lanes into the shift register and emit narrow(in[2]), narrow(in[1]), narrow(in[0]) in cycles n+1, n+2, n+3 with out_vld high (oldest first).
REQ-013 On in_vld in the cycle SHIFT sits at ph==2, the block SHALL load the shift register directly, so cadence-3 strobes give gapless out_vld.
REQ-014 On in_vld in SHIFT at ph 0 or 1, the block SHALL store the lanes in a one-entry holding buffer and set hold_full.
REQ-015 At ph==2 with hold_full set, the block SHALL move the holding buffer to the shift register, clear hold_full, and continue at ph 0 next cycle.
REQ-016 If ph==2, hold_full is set and in_vld is high, the block SHALL move holding to the shifter and store the new lanes in holding, with no drop.
REQ-017 If in_vld arrives while hold_full is set and ph!=2, the block SHALL drop the new lanes, keep holding unchanged and set ovf until reset.
REQ-018 At ph==2 with no pending data, the block SHALL return to IDLE and drive out_vld low next cycle.
REQ-019 When out_vld is low, the block SHALL hold out at its last value.
REQ-020 The block SHALL drive busy high in SHIFT or when hold_full is set.
REQ-021 narrow(x) SHALL reduce IW to OW by arithmetic shift right of IW-OW bits, computed at IW+1 bits, then saturated to [-2^(OW-1), 2^(OW-1)-1].

Reset
REQ-022 Reset SHALL force IDLE, ph=0, hold_full=0, out=0, out_vld=0, ovf=0, and clear the shift and holding registers to 0.
REQ-023 Reset mid-SHIFT SHALL discard pending samples; reset has priority over a simultaneous in_vld.

Configuration
REQ-024 With Z3_TO_Z1_ROUND_EN defined, narrow SHALL add 2^(IW-OW-1) before the shift (round half up).
REQ-025 Without Z3_TO_Z1_ROUND_EN, narrow SHALL truncate (floor), and no other behaviour SHALL change.

Structure
REQ-026 Shared package filter_pkg SHALL hold NPH=3, default IW/OW, and the IDLE/SHIFT state enum.
REQ-027 Narrowing SHALL sit in the combinational sub-module out_narrow (params IW, OW; macro-aware); the FSM, shifter and holding buffer live in z3_to_z1.

Verification
REQ-028 Reset release, in_vld=1 at cycle 0 with in={10*32, 20*32, 30*32} -> out 30, 20, 10 in cycles 1-3, out_vld 1,1,1, then 0.
REQ-029 in_vld every 3 cycles for 4 frames -> 12 consecutive out_vld cycles, order preserved, ovf=0.
REQ-030 Strobes at cycles 0, 1 and 2 -> frame0 out cycles 1-3, frame1 out cycles 4-6, frame2 dropped, ovf=1 from cycle 3 and held.
REQ-031 in[2]=47 and in[2]=48 -> out 1 and 1 without macro, 1 and 2 with macro; in[2]=32767 -> 1023 either way; in[2]=-32768 -> -1024.
REQ-032 Reset asserted at cycle 2 of a frame -> out_vld=0 and out=0 from the next cycle, busy=0, no residual samples afterwards.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared constants and types for the polyphase-to-serial filter blocks.
package filter_pkg;

  localparam int unsigned NPH    = 3;
  localparam int unsigned IW_DEF = 16;
  localparam int unsigned OW_DEF = 11;

  typedef enum logic {StIdle, StShift} state_e;

endpackage

// File: rtl/out_narrow.sv
// Combinational IW->OW narrowing: arithmetic shift with saturation.
// Z3_TO_Z1_ROUND_EN selects round-half-up instead of floor.
module out_narrow #(
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 11
) (
  input  logic [IW-1:0] x_i,
  output logic [OW-1:0] y_o
);

  localparam int unsigned Sh   = IW - OW;
  localparam int          MaxI = 2 ** (OW - 1) - 1;
  localparam logic signed [IW:0] MaxV = (IW + 1)'(MaxI);
  localparam logic signed [IW:0] MinV = (IW + 1)'(-MaxI - 1);
`ifdef Z3_TO_Z1_ROUND_EN
  localparam logic signed [IW:0] RndK = (IW + 1)'(2 ** (Sh - 1));
`endif

  logic signed [IW:0] ext;
  logic signed [IW:0] shr;

  always_comb begin
    // One guard bit so the rounding offset cannot wrap before saturation.
    ext = {x_i[IW-1], x_i};
`ifdef Z3_TO_Z1_ROUND_EN
    ext = ext + RndK;
`endif
    shr = ext >>> Sh;
    if (shr > MaxV) begin
      y_o = MaxV[OW-1:0];
    end else if (shr < MinV) begin
      y_o = MinV[OW-1:0];
    end else begin
      y_o = shr[OW-1:0];
    end
  end

endmodule

// File: rtl/z3_to_z1.sv
// Three-lane polyphase to serial converter with a one-entry holding buffer.
// Optional rounding in the narrower via Z3_TO_Z1_ROUND_EN.
module z3_to_z1
  import filter_pkg::*;
#(
  parameter int unsigned IW = IW_DEF,
  parameter int unsigned OW = OW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  input  logic [NPH-1:0][IW-1:0] in,
  output logic signed [OW-1:0]   out,
  output logic                   out_vld,
  output logic                   busy,
  output logic                   ovf
);

  localparam logic [1:0] PhLast = 2'(NPH - 1);

  state_e                 state_q, state_d;
  logic [1:0]             ph_q, ph_d;
  logic [NPH-1:0][IW-1:0] sr_q, sr_d;
  logic [NPH-1:0][IW-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   ovf_q, ovf_d;
  logic                   out_vld_q, out_vld_d;
  logic [OW-1:0]          out_q, out_d;
  logic [IW-1:0]          nar_x;
  logic [OW-1:0]          nar_y;

  out_narrow #(
    .IW (IW),
    .OW (OW)
  ) u_narrow (
    .x_i (nar_x),
    .y_o (nar_y)
  );

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    out_vld_d   = 1'b0;
    nar_x       = sr_q[1];

    unique case (state_q)
      StIdle: begin
        if (in_vld) begin
          sr_d      = in;
          nar_x     = in[2];
          out_vld_d = 1'b1;
          ph_d      = 2'd0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (ph_q != PhLast) begin
          // sr[2] is always the sample currently on out; shift the next one up.
          sr_d      = {sr_q[NPH-2:0], IW'(0)};
          nar_x     = sr_q[1];
          out_vld_d = 1'b1;
          ph_d      = ph_q + 2'd1;
          if (in_vld) begin
            if (hold_full_q) begin
              ovf_d = 1'b1;
            end else begin
              hold_d      = in;
              hold_full_d = 1'b1;
            end
          end
        end else if (hold_full_q) begin
          sr_d      = hold_q;
          nar_x     = hold_q[2];
          out_vld_d = 1'b1;
          ph_d      = 2'd0;
          if (in_vld) begin
            hold_d = in;
          end else begin
            hold_full_d = 1'b0;
          end
        end else if (in_vld) begin
          sr_d      = in;
          nar_x     = in[2];
          out_vld_d = 1'b1;
          ph_d      = 2'd0;
        end else begin
          ph_d    = 2'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    out_d = out_vld_d ? nar_y : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ph_q        <= 2'd0;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign busy    = (state_q == StShift) || hold_full_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_z3_to_z1.sv
// Directed bench for z3_to_z1: vector table plus hand-written multi-cycle sequences.
module tb_z3_to_z1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_vld;
  logic [2:0][15:0]        in_l;
  logic signed [10:0]      out_w;
  logic                    out_vld;
  logic                    busy;
  logic                    ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z3_to_z1 #(
    .IW (16),
    .OW (11)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (in_vld),
    .in      (in_l),
    .out     (out_w),
    .out_vld (out_vld),
    .busy    (busy),
    .ovf     (ovf)
  );

  typedef struct {
    logic             vld;
    logic [2:0][15:0] lanes;
    logic             ev;
    int               eo;
    logic             eb;
    logic             eovf;
  } vec_t;

  vec_t vecs[$];

`ifdef Z3_TO_Z1_ROUND_EN
  localparam int E48 = 2;
  localparam int EM33 = -1;
  localparam int E31 = 1;
`else
  localparam int E48 = 1;
  localparam int EM33 = -2;
  localparam int E31 = 0;
`endif

  function automatic logic [2:0][15:0] lanes3(int a2, int a1, int a0);
    logic [2:0][15:0] r;
    r[2] = 16'(a2);
    r[1] = 16'(a1);
    r[0] = 16'(a0);
    return r;
  endfunction

  function automatic void add(logic v, int a2, int a1, int a0, logic ev, int eo, logic eb,
                              logic eovf);
    vec_t t;
    t.vld   = v;
    t.lanes = lanes3(a2, a1, a0);
    t.ev    = ev;
    t.eo    = eo;
    t.eb    = eb;
    t.eovf  = eovf;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(string name, logic ev, int eo, logic eb, logic eovf);
    chk({name, ".out_vld"}, int'(out_vld), int'(ev));
    chk({name, ".out"}, int'(out_w), eo);
    chk({name, ".busy"}, int'(busy), int'(eb));
    chk({name, ".ovf"}, int'(ovf), int'(eovf));
  endtask

  // Apply inputs for one cycle; returns 1 time unit into the following cycle.
  task automatic cyc(logic r, logic v, logic [2:0][15:0] l);
    reset  = r;
    in_vld = v;
    in_l   = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int so[10];
    logic sv[10];
    logic sb[10];
    logic sf[10];
    logic st[10];

    reset  = 1'b1;
    in_vld = 1'b0;
    in_l   = '0;

    // Basic frame, then four cadence-3 frames emitting 1..12 gaplessly.
    add(1'b1, 30 * 32, 20 * 32, 10 * 32, 1'b1, 30, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, 20, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, 10, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b0, 10, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add(1'b1, (3 * k + 1) * 32, (3 * k + 2) * 32, (3 * k + 3) * 32, 1'b1, 3 * k + 1, 1'b1,
          1'b0);
      add(1'b0, 0, 0, 0, 1'b1, 3 * k + 2, 1'b1, 1'b0);
      add(1'b0, 0, 0, 0, 1'b1, 3 * k + 3, 1'b1, 1'b0);
    end
    add(1'b0, 0, 0, 0, 1'b0, 12, 1'b0, 1'b0);
    // Narrowing boundaries.
    add(1'b1, 47, 48, 32767, 1'b1, 1, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, E48, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, 1023, 1'b1, 1'b0);
    add(1'b1, -32768, -33, 31, 1'b1, -1024, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, EM33, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b1, E31, 1'b1, 1'b0);
    add(1'b0, 0, 0, 0, 1'b0, E31, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, lanes3(5000, 5000, 5000));
    chk_all("reset", 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(1'b0, vecs[i].vld, vecs[i].lanes);
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].eb, vecs[i].eovf);
    end

    // Strobes at 0, 1, 3: second frame waits in holding while the third arrives at ph 2.
    st = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    so = '{10, 11, 12, 20, 21, 22, 30, 31, 32, 32};
    sv = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      int f;
      f = (i == 0) ? 10 : (i == 1) ? 20 : 30;
      cyc(1'b0, st[i], lanes3(f * 32, (f + 1) * 32, (f + 2) * 32));
      chk_all($sformatf("hold%0d", i), sv[i], so[i], sv[i], 1'b0);
    end

    // Strobes at 0, 1, 2: the third frame is dropped and ovf sticks.
    st = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    so = '{100, 101, 102, 200, 201, 202, 202, 202, 0, 0};
    sv = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    sb = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    sf = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      int f;
      f = (i + 1) * 100;
      cyc(1'b0, st[i], lanes3(f * 32, (f + 1) * 32, (f + 2) * 32));
      chk_all($sformatf("drop%0d", i), sv[i], so[i], sb[i], sf[i]);
    end

    // Reset mid-frame, with a simultaneous strobe, discards everything.
    cyc(1'b0, 1'b1, lanes3(400 * 32, 401 * 32, 402 * 32));
    chk_all("rst_a", 1'b1, 400, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0);
    chk_all("rst_b", 1'b1, 401, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, lanes3(500 * 32, 501 * 32, 502 * 32));
    chk_all("rst_c", 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk_all($sformatf("rst_after%0d", i), 1'b0, 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
